reg_bank: RTL and testbench

//  Storage stage of the register file. Holds 2**SIZE words of WORD_LENGTH bits and

---
 rtl/reg_bank_pkg.sv | 21 ++
 rtl/reg_bank_cell.sv | 22 ++
 rtl/reg_bank.sv | 81 ++++++++
 tb/tb_reg_bank.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register-file storage stage: default geometry,
// the hardwired zero register, and the saturating write-counter type.
package reg_bank_pkg;

   localparam int WORD_LENGTH_DEF = 32;
   localparam int SIZE_DEF        = 5;
   localparam int NUM_REGS_DEF    = 2**SIZE_DEF;

   // Register 0 reads as zero, ignores writes and can never be reserved.
   localparam int ZERO_REG = 0;

   localparam int COUNT_W = 16;
   typedef logic [COUNT_W-1:0] count_t;
   localparam count_t COUNT_MAX = '1;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic count_t sat_inc(input count_t c);
      return (c == COUNT_MAX) ? c : c + count_t'(1);
   endfunction

endpackage

// File: rtl/reg_bank_cell.sv
// One register of the bank: a WORD_LENGTH-bit enabled flop with async active-low reset.
module reg_cell #(
   parameter int WORD_LENGTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   input  logic [WORD_LENGTH-1:0] d,
   output logic [WORD_LENGTH-1:0] q
);

   // Load d when enabled; reset clears the word.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/reg_bank.sv
// Register-file storage stage: 2**SIZE words, one synchronous write port, every
// word presented in parallel, a per-register busy scoreboard and a saturating
// count of accepted writes. All outputs come straight from flops.
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int WORD_LENGTH = WORD_LENGTH_DEF,
   parameter int SIZE        = SIZE_DEF
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                wr_en,
   input  logic [SIZE-1:0]                     wr_addr,
   input  logic [WORD_LENGTH-1:0]              wr_data,
   input  logic                                rsv_en,
   input  logic [SIZE-1:0]                     rsv_addr,
   output logic [(2**SIZE)*WORD_LENGTH-1:0]    reg_out,
   output logic [(2**SIZE)-1:0]                busy,
   output count_t                              wr_count
);

   localparam int NUM_REGS = 2**SIZE;
   localparam logic [SIZE-1:0] ZERO_ADDR = SIZE'(ZERO_REG);

   logic [NUM_REGS-1:0] wr_sel;
   logic [NUM_REGS-1:0] rsv_sel;
   logic                wr_accept;

   assign wr_accept = wr_en && (wr_addr != ZERO_ADDR);

   // One-hot write and reserve decode; the zero register is never selected.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      wr_sel  = '0;
      rsv_sel = '0;
      if (wr_en) begin
         wr_sel[wr_addr] = 1'b1;
      end
      if (rsv_en) begin
         rsv_sel[rsv_addr] = 1'b1;
      end
      wr_sel[ZERO_ADDR]  = 1'b0;
      rsv_sel[ZERO_ADDR] = 1'b0;
   end

   // Register 0 is a constant zero slice, not storage.
   assign reg_out[ZERO_REG*WORD_LENGTH +: WORD_LENGTH] = '0;

   // Storage for registers 1..NUM_REGS-1, each loading on its decoded strobe.
   // NOTE: the words are flops with reset, not a RAM, so clearing them on reset is free.
   for (genvar i = 1; i < NUM_REGS; i++) begin : g_cell
      reg_cell #(
         .WORD_LENGTH(WORD_LENGTH)
      ) u_cell (
         .clk  (clk),
         .reset(reset),
         .en   (wr_sel[i]),
         .d    (wr_data),
         .q    (reg_out[i*WORD_LENGTH +: WORD_LENGTH])
      );
   end

   // Scoreboard: write-back clears, reservation sets; a same-edge set wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy <= '0;
      end else begin
         busy <= (busy & ~wr_sel) | rsv_sel;
      end
   end

   // Count accepted writes, holding at the maximum.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_count <= '0;
      end else if (wr_accept) begin
         wr_count <= sat_inc(wr_count);
      end
   end

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: reset, write latency, r0 protection, scoreboard,
// back-to-back writes and wr_count saturation.
module tb_reg_bank;

   logic          clk;
   logic          reset;
   logic          wr_en;
   logic [4:0]    wr_addr;
   logic [31:0]   wr_data;
   logic          rsv_en;
   logic [4:0]    rsv_addr;
   logic [1023:0] reg_out;
   logic [31:0]   busy;
   logic [15:0]   wr_count;

   logic [31:0]   model [32];
   int            checks;
   int            errors;

   reg_bank #(
      .WORD_LENGTH(32),
      .SIZE       (5)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rsv_en  (rsv_en),
      .rsv_addr(rsv_addr),
      .reg_out (reg_out),
      .busy    (busy),
      .wr_count(wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] slice(input int i);
      return reg_out[i*32 +: 32];
   endfunction

   task automatic check_all_slices(input string tag);
      for (int i = 0; i < 32; i++) begin
         check($sformatf("%s slice%0d", tag, i), slice(i), model[i]);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rsv_en   = 1'b0;
      rsv_addr = '0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = '0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clear_model();
      idle();

      // Power-on reset.
      reset = 1'b0;
      step();
      step();
      check("por busy", busy, 32'h0);
      check("por wr_count", {16'h0, wr_count}, 32'h0);
      check_all_slices("por");
      reset = 1'b1;
      step();

      // Write 0xDEADBEEF to r5; no bypass before the edge.
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      #1;
      check("r5 before edge", slice(5), 32'h0);
      step();
      idle();
      model[5] = 32'hDEADBEEF;
      check_all_slices("wr r5");
      check("wr r5 count", {16'h0, wr_count}, 32'd1);

      // Write and reserve r0: both dropped.
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
      rsv_en = 1'b1; rsv_addr = 5'd0;
      step();
      idle();
      check("r0 slice", slice(0), 32'h0);
      check("r0 busy", busy, 32'h0);
      check("r0 count", {16'h0, wr_count}, 32'd1);

      // Reserve r7.
      rsv_en = 1'b1; rsv_addr = 5'd7;
      step();
      idle();
      check("rsv r7 busy", busy, 32'h0000_0080);

      // Write and reserve r7 on the same edge: set wins, data lands.
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
      rsv_en = 1'b1; rsv_addr = 5'd7;
      step();
      idle();
      model[7] = 32'h12345678;
      check("wr+rsv r7 busy", busy, 32'h0000_0080);
      check("wr+rsv r7 data", slice(7), 32'h12345678);
      check("wr+rsv r7 count", {16'h0, wr_count}, 32'd2);

      // Reserve r3 while r7 stays busy, then reserve r3 again.
      rsv_en = 1'b1; rsv_addr = 5'd3;
      step();
      step();
      idle();
      check("rsv r3 twice busy", busy, 32'h0000_0088);

      // Write r7 only: clears its busy bit, r3 stays busy.
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFEF00D;
      step();
      idle();
      model[7] = 32'hCAFEF00D;
      check("wr r7 busy", busy, 32'h0000_0008);
      check("wr r7 data", slice(7), 32'hCAFEF00D);

      // Write a non-busy register: its busy bit stays clear.
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0099;
      step();
      idle();
      model[9] = 32'h0000_0099;
      check("wr r9 busy", busy, 32'h0000_0008);
      check("wr r9 count", {16'h0, wr_count}, 32'd4);
      check_all_slices("pre-reset");

      // Reset asserted mid-cycle takes effect before the next edge.
      @(posedge clk);
      #4;
      wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h5555_AAAA;
      reset = 1'b0;
      #1;
      clear_model();
      check("mid reset busy", busy, 32'h0);
      check("mid reset count", {16'h0, wr_count}, 32'h0);
      check_all_slices("mid reset");
      step();
      check("in-flight write dropped", slice(2), 32'h0);
      idle();
      reset = 1'b1;
      step();

      // Back-to-back writes to r1..r31.
      for (int i = 1; i < 32; i++) begin
         wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i) * 32'h01010101;
         model[i] = 32'(i) * 32'h01010101;
         step();
      end
      idle();
      check_all_slices("b2b");
      check("b2b count", {16'h0, wr_count}, 32'd31);
      check("b2b busy", busy, 32'h0);

      // Saturation: 65540 accepted writes from a fresh reset.
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
      wr_en = 1'b1; wr_addr = 5'd1;
      for (int i = 0; i < 65534; i++) begin
         wr_data = 32'(i);
         step();
      end
      check("sat 65534", {16'h0, wr_count}, 32'h0000_FFFE);
      wr_data = 32'h0001_0000;
      step();
      check("sat 65535", {16'h0, wr_count}, 32'h0000_FFFF);
      wr_data = 32'h0001_0001;
      step();
      check("sat 65536 no wrap", {16'h0, wr_count}, 32'h0000_FFFF);
      for (int i = 0; i < 4; i++) begin
         wr_data = 32'hA000_0000 + 32'(i);
         step();
      end
      idle();
      check("sat 65540", {16'h0, wr_count}, 32'h0000_FFFF);
      check("sat last data", slice(1), 32'hA000_0003);

      // Reset clears the saturated counter.
      reset = 1'b0;
      #2;
      check("sat reset count", {16'h0, wr_count}, 32'h0);
      check("sat reset r1", slice(1), 32'h0);
      step();
      reset = 1'b1;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
